// File: rtl/ecdsa_cmd_sequencer.sv
// Sequences one ECDSA command: fetch operands from RXADDR, run the core under a watchdog, write the result to TXADDR.
// Overhead is 11 cycles plus core time by default; there is no backpressure (the memory and core are always ready).
module ecdsa_cmd_sequencer #(
    parameter int N_OPS      = 3,
    parameter int MEM_RD_LAT = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     command,
    input  logic [31:0]     rxaddr,
    input  logic [31:0]     txaddr,
    output logic [31:0]     status,
    output logic [16:0]     mem_addr,
    output logic [1023:0]   mem_din,
    input  logic [1023:0]   mem_dout,
    output logic [127:0]    mem_we,
    output logic [1023:0]   core_a,
    output logic [1023:0]   core_b,
    output logic [1023:0]   core_m,
    output logic            core_start,
    input  logic            core_done,
    input  logic [1023:0]   core_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_RD, S_START, S_WAIT, S_WR, S_DONE
    } state_t;

    localparam logic [1:0]  K_LAST   = 2'(N_OPS - 1);
    localparam logic [7:0]  LAT_LAST = 8'(MEM_RD_LAT - 1);
    localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);

    state_t          state_q;
    logic            cmd_q;
    logic            edge_q;
    logic            done_q, busy_q, error_q;
    logic [16:0]     mem_addr_q;
    logic [16:0]     tx_q;
    logic [1023:0]   mem_din_q;
    logic [127:0]    mem_we_q;
    logic [1023:0]   core_a_q, core_b_q, core_m_q;
    logic            core_start_q;
    logic [1:0]      k_q;
    logic [7:0]      lat_q;
    logic [31:0]     wdog_q;

    logic            misalign_d;
    logic [16:0]     next_rd_addr_d;
    logic            unused_inputs;

    assign misalign_d     = (rxaddr[6:0] != 7'd0) || (txaddr[6:0] != 7'd0);
    assign next_rd_addr_d = mem_addr_q + 17'd128;
    assign unused_inputs  = ^{command[31:1], rxaddr[31:17], txaddr[31:17]};

    // cmd_q resets high so a start bit already held across reset is not taken as an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cmd_q        <= 1'b1;
            edge_q       <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            mem_addr_q   <= '0;
            tx_q         <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_m_q     <= '0;
            core_start_q <= 1'b0;
            k_q          <= '0;
            lat_q        <= '0;
            wdog_q       <= '0;
        end else begin
            cmd_q  <= command[0];
            edge_q <= command[0] & ~cmd_q;
            case (state_q)
                S_IDLE: begin
                    if (edge_q) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    tx_q <= txaddr[16:0];
                    if (misalign_d) begin
                        error_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        busy_q     <= 1'b1;
                        k_q        <= '0;
                        lat_q      <= '0;
                        mem_addr_q <= rxaddr[16:0];
                        state_q    <= S_RD;
                    end
                end
                S_RD: begin
                    if (lat_q == LAT_LAST) begin
                        lat_q <= '0;
                        k_q   <= k_q + 2'd1;
                        case (k_q)
                            2'd0:    core_a_q <= mem_dout;
                            2'd1:    core_b_q <= mem_dout;
                            default: core_m_q <= mem_dout;
                        endcase
                        if (k_q == K_LAST) begin
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end else begin
                            mem_addr_q <= next_rd_addr_d;
                        end
                    end else begin
                        lat_q <= lat_q + 8'd1;
                    end
                end
                S_START: begin
                    core_start_q <= 1'b0;
                    wdog_q       <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        mem_din_q  <= core_result;
                        mem_addr_q <= tx_q;
                        mem_we_q   <= '1;
                        state_q    <= S_WR;
                    end else if (wdog_q == WD_LAST) begin
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        wdog_q <= wdog_q + 32'd1;
                    end
                end
                S_WR: begin
                    mem_we_q <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (!command[0]) begin
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign status     = {29'd0, error_q, busy_q, done_q};
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_m     = core_m_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_ecdsa_cmd_sequencer.sv
// Bench for ecdsa_cmd_sequencer: table-driven and random commands against a memory-level model, plus reset/toggle corner cases.
module tb_ecdsa_cmd_sequencer;
    localparam int N_OPS = 3;
    localparam int LAT   = 2;
    localparam int TMO   = 50;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [31:0]     command = '0, rxaddr = '0, txaddr = '0;
    logic [31:0]     status;
    logic [16:0]     mem_addr;
    logic [1023:0]   mem_din, mem_dout, core_a, core_b, core_m;
    logic [127:0]    mem_we;
    logic            core_start, core_done;
    logic            core_done_m = 1'b0, spur_done = 1'b0;
    logic [1023:0]   core_result = '0, core_res_hold;

    assign core_done = core_done_m | spur_done;

    ecdsa_cmd_sequencer #(.N_OPS(N_OPS), .MEM_RD_LAT(LAT), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn), .command(command), .rxaddr(rxaddr), .txaddr(txaddr),
        .status(status), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_we(mem_we), .core_a(core_a), .core_b(core_b), .core_m(core_m),
        .core_start(core_start), .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 128 KiB operand memory, 1024-bit words, one registered read stage.
    logic [1023:0] mem [0:1023];
    logic          ld_vld = 1'b0;
    logic [9:0]    ld_idx = '0;
    logic [1023:0] ld_dat = '0;
    always @(posedge clk) begin
        if (|mem_we)
            for (int b = 0; b < 128; b++)
                if (mem_we[b]) mem[mem_addr[16:7]][b*8 +: 8] <= mem_din[b*8 +: 8];
        if (ld_vld) mem[ld_idx] <= ld_dat;
        mem_dout <= mem[mem_addr[16:7]];
    end

    // Core model: result = a + b + m + 1, returned core_dly cycles after the start pulse.
    int core_dly = 1;
    bit core_en  = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (core_start && core_en) begin
                core_res_hold = core_a + core_b + core_m + 1024'd1;
                repeat (core_dly) @(negedge clk);
                core_result = core_res_hold;
                core_done_m = 1'b1;
                @(negedge clk);
                core_done_m = 1'b0;
                core_result = '0;
            end
        end
    end

    int start_cnt = 0, start_cyc = 0, we_cnt = 0, we_cyc = 0, consec_cnt = 0, done_rise = 0;
    logic prev_start = 1'b0, prev_done = 1'b0;
    always @(negedge clk) begin
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end
        if (core_start && prev_start) consec_cnt <= consec_cnt + 1;
        prev_start <= core_start;
        if (|mem_we) begin
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
        end
        if (status[0] && !prev_done) done_rise <= done_rise + 1;
        prev_done <= status[0];
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h_%h want %h_%h", nm, act[1023:960], act[63:0],
                     exp[1023:960], exp[63:0]);
        end
    endtask

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic load_word(input int byte_addr, input logic [1023:0] d);
        ld_idx = 10'(byte_addr / 128);
        ld_dat = d;
        ld_vld = 1'b1;
        @(negedge clk);
        ld_vld = 1'b0;
    endtask

    task automatic preload(input logic [31:0] rx, input bit nominal);
        logic [1023:0] one_1020;
        one_1020       = '0;
        one_1020[1020] = 1'b1;
        for (int k = 0; k < N_OPS; k++) begin
            int a;
            a = (int'(rx % 131072) + 128 * k) % 131072;
            load_word(a, nominal ? ((k == 0) ? one_1020 : '0) : rnd1024());
        end
    endtask

    // One full command, checked against the memory-level model.
    task automatic run_cmd(input logic [31:0] rx, input logic [31:0] tx, input int dly,
                           input bit en, input logic [31:0] exp_st);
        bit            mis, got, busy_ok;
        logic [1023:0] ops [3];
        logic [1023:0] exp_res, old_tx;
        int            tx_idx, s0, w0, r0, e0, done_c;
        mis = (rx % 128 != 0) || (tx % 128 != 0);
        for (int k = 0; k < 3; k++)
            ops[k] = mem[((int'(rx % 131072) + 128 * k) % 131072) / 128];
        exp_res = ops[0] + ops[1] + ops[2] + 1024'd1;
        tx_idx  = int'(tx % 131072) / 128;
        old_tx  = mem[tx_idx];
        s0 = start_cnt; w0 = we_cnt; r0 = done_rise;
        core_dly = dly; core_en = en; rxaddr = rx; txaddr = tx;
        @(negedge clk);
        command[0] = 1'b1;
        e0 = cyc + 1;
        got = 1'b0; busy_ok = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (status[0]) got = 1'b1;
            else if (status !== ((!mis && cyc >= e0 + 2) ? 32'h2 : 32'h0)) busy_ok = 1'b0;
        end
        done_c = cyc;
        chk("done_seen", 1024'(got), 1024'(1));
        chk("status_done", 1024'(status), 1024'(exp_st));
        chk("busy_phase", 1024'(busy_ok), 1024'(1));
        if (mis) begin
            chk("mis_latency", 1024'(done_c), 1024'(e0 + 2));
            chk("mis_no_start", 1024'(start_cnt), 1024'(s0));
            chk("mis_no_write", 1024'(we_cnt), 1024'(w0));
        end else begin
            chk("one_start", 1024'(start_cnt), 1024'(s0 + 1));
            chk("start_time", 1024'(start_cyc), 1024'(e0 + 2 + N_OPS * LAT));
            chk("core_a", core_a, ops[0]);
            chk("core_b", core_b, ops[1]);
            chk("core_m", core_m, ops[2]);
            if (en) begin
                chk("one_write", 1024'(we_cnt), 1024'(w0 + 1));
                chk("we_to_done", 1024'(we_cyc), 1024'(done_c - 1));
                chk("done_time", 1024'(done_c), 1024'(start_cyc + dly + 2));
                chk("mem_addr_tx", 1024'(mem_addr), 1024'(tx % 131072));
                chk("mem_din", mem_din, exp_res);
            end else begin
                chk("wdog_no_write", 1024'(we_cnt), 1024'(w0));
                chk("wdog_time", 1024'(done_c), 1024'(start_cyc + 1 + TMO));
            end
        end
        chk("mem_tx", mem[tx_idx], (en && !mis) ? exp_res : old_tx);
        repeat (3) @(negedge clk);
        chk("done_held", 1024'(status), 1024'(exp_st));
        command[0] = 1'b0;
        @(negedge clk);
        chk("status_clear", 1024'(status), 1024'(0));
        chk("done_once", 1024'(done_rise), 1024'(r0 + 1));
    endtask

    task automatic reset_mid(input bit in_wr);
        logic [1023:0] old;
        bit            hit;
        int            s1;
        rxaddr = 32'h800; txaddr = 32'h900; core_en = 1'b1; core_dly = 4;
        old = mem[32'h900 / 128];
        @(negedge clk);
        command[0] = 1'b1;
        hit = 1'b0;
        if (!in_wr) begin
            repeat (5) @(negedge clk);
            hit = (status == 32'h2);
        end else begin
            for (int i = 0; i < 100 && !hit; i++) begin
                @(negedge clk);
                if (|mem_we) hit = 1'b1;
            end
        end
        chk(in_wr ? "rst_reach_wr" : "rst_reach_rd", 1024'(hit), 1024'(1));
        resetn = 1'b0;
        #1;
        chk("rst_status", 1024'(status), 1024'(0));
        chk("rst_mem_we", 1024'(mem_we), 1024'(0));
        chk("rst_mem_addr", 1024'(mem_addr), 1024'(0));
        chk("rst_mem_din", mem_din, '0);
        chk("rst_core_ops", core_a | core_b | core_m, '0);
        chk("rst_core_start", 1024'(core_start), 1024'(0));
        repeat (2) @(negedge clk);
        chk("rst_mem_kept", mem[32'h900 / 128], old);
        resetn = 1'b1;
        s1 = start_cnt;
        repeat (20) @(negedge clk);
        chk("rst_held_cmd_idle", 1024'(status), 1024'(0));
        chk("rst_held_cmd_nostart", 1024'(start_cnt), 1024'(s1));
        command[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] rx;
        logic [31:0] tx;
        int          dly;
        bit          en;
        logic [31:0] exp_st;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int s0, w0, r0;
        bit got;
        logic [31:0] rx, tx;

        tbl[0] = '{32'h0000_0100, 32'h0000_0080, 20, 1'b1, 32'h1};
        tbl[1] = '{32'h0001_FF00, 32'h0000_0400,  5, 1'b1, 32'h1};
        tbl[2] = '{32'h0000_0200, 32'h0000_0084,  3, 1'b1, 32'h5};
        tbl[3] = '{32'h0000_0141, 32'h0000_0080,  3, 1'b1, 32'h5};
        tbl[4] = '{32'h0000_0300, 32'h0000_0380,  1, 1'b0, 32'h5};
        tbl[5] = '{32'hABC0_0180, 32'hFFFE_0480,  9, 1'b1, 32'h1};

        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_status", 1024'(status), 1024'(0));
        chk("reset_mem_we", 1024'(mem_we), 1024'(0));
        chk("reset_core_start", 1024'(core_start), 1024'(0));
        chk("reset_mem_addr", 1024'(mem_addr), 1024'(0));
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            preload(tbl[i].rx, i == 0);
            run_cmd(tbl[i].rx, tbl[i].tx, tbl[i].dly, tbl[i].en, tbl[i].exp_st);
        end

        // Spurious core_done in IDLE must do nothing.
        s0 = start_cnt; w0 = we_cnt;
        @(negedge clk); spur_done = 1'b1;
        @(negedge clk); spur_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("spur_status", 1024'(status), 1024'(0));
        chk("spur_no_write", 1024'(we_cnt), 1024'(w0));
        chk("spur_no_start", 1024'(start_cnt), 1024'(s0));

        preload(32'h800, 1'b0);
        load_word(32'h900, rnd1024());
        reset_mid(1'b0);
        run_cmd(32'h800, 32'h900, 6, 1'b1, 32'h1);
        load_word(32'h900, rnd1024());
        reset_mid(1'b1);
        run_cmd(32'h800, 32'h900, 6, 1'b1, 32'h1);

        // Start bit toggled 1->0->1 while busy: exactly one run.
        preload(32'hA00, 1'b0);
        rxaddr = 32'hA00; txaddr = 32'hB00; core_en = 1'b1; core_dly = 10;
        s0 = start_cnt; r0 = done_rise;
        @(negedge clk); command[0] = 1'b1;
        repeat (3) @(negedge clk); command[0] = 1'b0;
        repeat (2) @(negedge clk); command[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (status[0]) got = 1'b1;
        end
        chk("tog_done", 1024'(got), 1024'(1));
        chk("tog_one_start", 1024'(start_cnt), 1024'(s0 + 1));
        repeat (10) @(negedge clk);
        chk("tog_done_held", 1024'(status), 1024'(1));
        command[0] = 1'b0;
        @(negedge clk);
        chk("tog_clear", 1024'(status), 1024'(0));
        repeat (20) @(negedge clk);
        chk("tog_no_rerun", 1024'(start_cnt), 1024'(s0 + 1));
        chk("tog_done_once", 1024'(done_rise), 1024'(r0 + 1));

        for (int i = 0; i < 6; i++) begin
            rx = {15'd0, 10'($urandom_range(0, 1023)), 7'd0};
            tx = {15'd0, 10'($urandom_range(0, 1023)), 7'd0};
            if ($urandom_range(0, 4) == 0) tx[6:0] = 7'($urandom_range(1, 127));
            preload(rx, 1'b0);
            run_cmd(rx, tx, $urandom_range(1, 30), 1'b1, (tx[6:0] != 7'd0) ? 32'h5 : 32'h1);
        end

        chk("no_back_to_back_start", 1024'(consec_cnt), 1024'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ecdsa_cmd_sequencer.md
# ecdsa_cmd_sequencer

Command sequencer between the AXI-lite CSR block and the 1024-bit operand memory in the ECDSA project wrapper. The CSR block presents three registers to this block: COMMAND (r0), RXADDR (r1) and TXADDR (r2). On a start command, the sequencer:
- fetches up to three 1024-bit operands from memory at RXADDR,
- launches the arithmetic core and waits for its result, with a watchdog,
- writes the result to TXADDR,
- reports done/busy/error through STATUS until software clears the command.

## Interface
Parameters:
- N_OPS, 3, operands fetched per command (1..3).
- MEM_RD_LAT, 2, memory read latency in cycles, from address to valid mem_dout.
- TIMEOUT, 65535, maximum WAIT_CORE cycles before an error is flagged.

Ports:
- clk  in  1  system clock; memory port shares it.
- resetn  in  1  reset, asynchronous, active-low.
- command  in  32  CSR r0; bit0 = start, other bits ignored.
- rxaddr  in  32  CSR r1; operand byte address, low 17 bits used.
- txaddr  in  32  CSR r2; result byte address, low 17 bits used.
- status  out  32  bit0 done, bit1 busy, bit2 error; bits 31:3 are 0.
- mem_addr  out  17  memory byte address.
- mem_din  out  1024  memory write data.
- mem_dout  in  1024  memory read data.
- mem_we  out  128  byte write enables.
- core_a, core_b, core_m  out  1024 each  operand registers 0, 1, 2.
- core_start  out  1  single-cycle start pulse to the core.
- core_done  in  1  single-cycle completion pulse from the core.
- core_result  in  1024  core result, valid while core_done=1.

## Operation
Reset values:
- All outputs 0.
- Operand registers 0.
- State IDLE.
- Watchdog counter 0.

Address rules:
- Operand k is read at rxaddr + 128·k, for k = 0..N_OPS-1.
- Address arithmetic is 17-bit and wraps modulo 2^17.
- An address is misaligned if any of its bits [6:0] is nonzero. This check applies to both rxaddr and txaddr.

State machine:
- IDLE: move to CHECK on a 0→1 transition of command[0] (registered edge detect). A command[0] held at 1 after reset does not trigger a start.
- CHECK: one cycle. If either address is misaligned, set error and go to DONE. Otherwise set busy, clear k, and go to RD.
- RD: drive mem_addr = rxaddr+128·k with mem_we=0, and hold the address for MEM_RD_LAT cycles. On the last of those cycles, capture mem_dout into operand k. Then increment k; if k=N_OPS go to START, otherwise repeat RD.
- START: pulse core_start=1 for exactly one cycle, clear the watchdog, go to WAIT_CORE.
- WAIT_CORE: when core_done=1, latch core_result into the output buffer and go to WR. When the watchdog reaches TIMEOUT, set error, clear busy, and go to DONE without writing memory.
- WR: one cycle with mem_addr=txaddr, mem_din=result, mem_we all ones. Next cycle mem_we=0; go to DONE.
- DONE: done=1, busy=0. Stay in DONE while command[0]=1. When command[0]=0, go to IDLE; done and error clear on that transition.

Other rules:
- In IDLE, mem_addr holds its last value, mem_we=0, mem_din holds the last result.
- Changes to rxaddr/txaddr after CHECK are ignored: both addresses are latched in CHECK.
- Deasserting command[0] while busy is ignored until DONE is reached.
- core_done outside WAIT_CORE is ignored.
- Asserting resetn low at any point, including mid-read or mid-write, returns everything to the reset values within the same cycle. No partial write completes after reset.

## Timing
- Start edge to CHECK: 1 cycle after the edge is registered. CHECK to the first RD address: 1 cycle.
- Fetch: N_OPS·MEM_RD_LAT cycles.
- core_start is asserted the cycle after the last operand capture.
- core_done to mem_we: 1 cycle (WR). mem_we to status.done=1: 1 cycle.
- Total fixed overhead excluding core time, with defaults: 2 + 6 + 1 + 1 + 1 = 11 cycles.
- status is registered and changes only on clk edges.
- core_start is never asserted on consecutive cycles.

## Test plan
- Nominal: N_OPS=1. Write mem[0x100] = 1<<1020. Set rxaddr=0x100, txaddr=0x80, command 0→1. A core model returns operand+1 after 20 cycles.
  - core_a = 1<<1020.
  - mem[0x80] = (1<<1020)+1.
  - status = 0x1.
  - Writing command=0 gives status = 0x0 on the next cycle.
- Three operands: N_OPS=3, rxaddr=0x1FF00. Operands are read at 0x1FF00, 0x1FF80 and 0x00000 (address wraps). Verify each operand register. Exactly one core_start pulse is issued.
- Misaligned address: txaddr=0x84 → status=0x5 within 2 cycles of the start edge. No memory write, no core_start.
- Watchdog: TIMEOUT=50 and the core never responds → status=0x5 after exactly 50 WAIT_CORE cycles; mem_we stays 0 throughout.
- Reset mid-operation: assert resetn=0 during RD and again during WR.
  - All outputs go to 0 immediately.
  - Memory is unchanged.
  - After release, command held at 1 does not restart the sequence; a fresh 0→1 edge does.
- Edge cases:
  - Spurious core_done while IDLE is ignored.
  - command toggled 1→0→1 while busy: a single run, done asserted once.
  - command still 1 at DONE: done stays high until command is 0.
